// File: rtl/ntt_stage_sched.sv
// Stage scheduler for the radix-2^RADIX_K1 NTT datapath: meters AGU issue per stage,
// waits for every butterfly group to write back, flips the ping-pong bank and flags done.
module ntt_stage_sched #(
  parameter int LOGN     = 8,
  parameter int RADIX_K1 = 4,
  parameter int D_WIDTH  = 16,
  localparam int K  = LOGN / RADIX_K1,
  localparam int G  = 1 << (LOGN - RADIX_K1),
  localparam int CW = $clog2(G + 1),
  localparam int SW = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               wb_valid,
  input  logic [D_WIDTH-1:0] agu_l,
  output logic               agu_enable,
  output logic [SW-1:0]      stage,
  output logic               rd_bank,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] ISSUE_LAST = CW'(G - 1);
  localparam logic [CW:0]   G_EXT      = (CW + 1)'(G);
  localparam logic [SW-1:0] STAGE_LAST = SW'(K - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] wb_cnt_q, wb_cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          rd_bank_q, rd_bank_d;
  logic          err_q, err_d;
  logic          agu_enable_q, agu_enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW:0]   wb_sum;
  logic          wb_over;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    stage_d     = stage_q;
    rd_bank_d   = rd_bank_q;
    err_d       = err_q;

    // One extra bit so a write-back beyond G is visible instead of wrapping
    wb_sum  = {1'b0, wb_cnt_q} + (CW + 1)'(wb_valid);
    wb_over = (wb_sum > G_EXT);

    case (state_q)
      S_IDLE: begin
        if (wb_valid) begin
          err_d = 1'b1;
        end
        if (start && !abort) begin
          state_d     = S_ISSUE;
          issue_cnt_d = '0;
          wb_cnt_d    = '0;
          stage_d     = '0;
          rd_bank_d   = 1'b0;
          err_d       = 1'b0;
        end
      end

      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + CW'(1);
        if (agu_l != D_WIDTH'(stage_q)) begin
          err_d = 1'b1;
        end
        if (wb_valid) begin
          if (wb_over) begin
            err_d = 1'b1;
          end else begin
            wb_cnt_d = wb_sum[CW-1:0];
          end
        end
        if (issue_cnt_q == ISSUE_LAST) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (wb_valid) begin
          if (wb_over) begin
            err_d = 1'b1;
          end else begin
            wb_cnt_d = wb_sum[CW-1:0];
          end
        end
        // Saturated count still satisfies the exit, so a surplus pulse cannot stall us
        if (wb_sum >= G_EXT) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            stage_d     = stage_q + SW'(1);
            rd_bank_d   = ~rd_bank_q;
            issue_cnt_d = '0;
            wb_cnt_d    = '0;
          end
        end
      end

      S_DONE: begin
        if (wb_valid) begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      stage_d   = '0;
      rd_bank_d = 1'b0;
    end

    agu_enable_d = (state_d == S_ISSUE);
    busy_d       = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      wb_cnt_q     <= '0;
      stage_q      <= '0;
      rd_bank_q    <= 1'b0;
      err_q        <= 1'b0;
      agu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      stage_q      <= stage_d;
      rd_bank_q    <= rd_bank_d;
      err_q        <= err_d;
      agu_enable_q <= agu_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign agu_enable = agu_enable_q;
  assign stage      = stage_q;
  assign rd_bank    = rd_bank_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched: write-back echo model plus a queue of expected
// issue-start and done cycles derived from the write-back latency of each run.
module tb_ntt_stage_sched;

  localparam int LOGN     = 8;
  localparam int RADIX_K1 = 4;
  localparam int D_WIDTH  = 16;
  localparam int K        = LOGN / RADIX_K1;
  localparam int G        = 1 << (LOGN - RADIX_K1);
  localparam int SW       = (K > 1) ? $clog2(K) : 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               wb_valid;
  logic [D_WIDTH-1:0] agu_l;
  logic               agu_enable;
  logic [SW-1:0]      stage;
  logic               rd_bank;
  logic               busy;
  logic               done;
  logic               err;

  ntt_stage_sched #(
    .LOGN    (LOGN),
    .RADIX_K1(RADIX_K1),
    .D_WIDTH (D_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .wb_valid  (wb_valid),
    .agu_l     (agu_l),
    .agu_enable(agu_enable),
    .stage     (stage),
    .rd_bank   (rd_bank),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  rise_idx = 0;
  int  en_run = 0;
  int  lat = 4;
  bit  echo_en = 1'b0;
  bit  force_l = 1'b0;
  bit  skip_len = 1'b0;
  bit  prev_en = 1'b0;
  int  exp_err = 0;
  int  exp_rise_q[$];
  int  exp_done_q[$];
  bit  wb_sched[int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, run the monitor on the new outputs, then drive this cycle's inputs
  task automatic step();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (agu_enable === 1'b1 && !prev_en) begin
      if (exp_rise_q.size() > 0) e = exp_rise_q.pop_front();
      else e = -1;
      $display("cycle %0d: issue start stage=%0d rd_bank=%0d", cyc, stage, rd_bank);
      check("issue_start_cycle", 32'(cyc), 32'(e));
      check("stage_at_issue", 32'(stage), 32'(rise_idx));
      check("rd_bank_at_issue", 32'(rd_bank), 32'(rise_idx % 2));
      check("busy_at_issue", 32'(busy), 32'(1));
      rise_idx++;
    end
    if (prev_en && agu_enable !== 1'b1) begin
      if (!skip_len) check("issue_len", 32'(en_run), 32'(G));
      en_run   = 0;
      skip_len = 1'b0;
    end
    if (agu_enable === 1'b1) en_run++;
    if (done === 1'b1) begin
      if (exp_done_q.size() > 0) e = exp_done_q.pop_front();
      else e = -1;
      $display("cycle %0d: done err=%0d", cyc, err);
      check("done_cycle", 32'(cyc), 32'(e));
      check("stage_at_done", 32'(stage), 32'(K - 1));
      check("rd_bank_at_done", 32'(rd_bank), 32'((K - 1) % 2));
      check("err_at_done", 32'(err), 32'(exp_err));
    end
    prev_en = (agu_enable === 1'b1);
    if (echo_en && agu_enable === 1'b1) wb_sched[cyc + lat] = 1'b1;
    wb_valid = wb_sched.exists(cyc);
    if (wb_valid) wb_sched.delete(cyc);
    agu_l = force_l ? D_WIDTH'(1) : D_WIDTH'(stage);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  // Start in the current cycle; each stage occupies G issue cycles plus max(L,1) drain
  task automatic start_run(input int l);
    int per;
    per      = G + ((l > 1) ? l : 1);
    lat      = l;
    echo_en  = 1'b1;
    start    = 1'b1;
    t0       = cyc;
    rise_idx = 0;
    for (int s = 0; s < K; s++) exp_rise_q.push_back(t0 + 1 + s * per);
    exp_done_q.push_back(t0 + K * per + 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_agu_enable"}, 32'(agu_enable), 32'(0));
    check({tag, "_stage"}, 32'(stage), 32'(0));
    check({tag, "_rd_bank"}, 32'(rd_bank), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    wb_valid = 1'b0;
    agu_l    = '0;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Nominal run, L=4
    exp_err = 0;
    start_run(4);
    step();
    check("busy_after_start", 32'(busy), 32'(1));
    run_until(t0 + 45);
    check("nominal_done_pending", 32'(exp_done_q.size()), 32'(0));
    check("nominal_rise_pending", 32'(exp_rise_q.size()), 32'(0));
    check("nominal_stage_hold", 32'(stage), 32'(K - 1));
    check("nominal_rd_bank_hold", 32'(rd_bank), 32'(1));
    check("nominal_idle_busy", 32'(busy), 32'(0));

    // Bursty write-back: nothing until cycle 30, then 16 back-to-back pulses
    step();
    echo_en  = 1'b0;
    start    = 1'b1;
    t0       = cyc;
    rise_idx = 0;
    exp_rise_q.push_back(t0 + 1);
    exp_rise_q.push_back(t0 + 46);
    exp_done_q.push_back(t0 + 66);
    for (int c = 30; c < 46; c++) wb_sched[t0 + c] = 1'b1;
    run_until(t0 + 45);
    check("bursty_drain_enable", 32'(agu_enable), 32'(0));
    check("bursty_drain_busy", 32'(busy), 32'(1));
    echo_en = 1'b1;
    lat     = 4;
    run_until(t0 + 70);
    check("bursty_done_pending", 32'(exp_done_q.size()), 32'(0));

    // Abort in ISSUE cycle 8, then restart at cycle 12
    step();
    start_run(4);
    run_until(t0 + 8);
    abort    = 1'b1;
    skip_len = 1'b1;
    echo_en  = 1'b0;
    wb_sched.delete();
    step();
    check("abort_enable", 32'(agu_enable), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_stage", 32'(stage), 32'(0));
    check("abort_rd_bank", 32'(rd_bank), 32'(0));
    exp_rise_q.delete();
    exp_done_q.delete();
    run_until(t0 + 12);
    start_run(4);
    run_until(t0 + 45);
    check("abort_restart_done_pending", 32'(exp_done_q.size()), 32'(0));

    // Write-back in IDLE, then a 17th write-back in stage 0 (L=0 plus one extra)
    step();
    wb_valid = 1'b1;
    step();
    check("err_idle_wb", 32'(err), 32'(1));
    exp_err = 1;
    start_run(0);
    wb_sched[t0 + 17] = 1'b1;
    step();
    check("err_cleared_by_start", 32'(err), 32'(0));
    run_until(t0 + 18);
    check("err_wb_overflow", 32'(err), 32'(1));
    run_until(t0 + 38);
    check("overflow_done_pending", 32'(exp_done_q.size()), 32'(0));

    // agu_l stuck at 1 during stage 0
    step();
    force_l = 1'b1;
    exp_err = 1;
    start_run(4);
    run_until(t0 + 2);
    check("err_agu_mismatch", 32'(err), 32'(1));
    run_until(t0 + 16);
    force_l = 1'b0;
    run_until(t0 + 45);
    check("agu_mismatch_done_pending", 32'(exp_done_q.size()), 32'(0));

    // start and abort together in IDLE: stay idle, err kept
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    check("start_abort_busy", 32'(busy), 32'(0));
    check("start_abort_enable", 32'(agu_enable), 32'(0));
    check("start_abort_err_kept", 32'(err), 32'(1));
    repeat (3) step();

    // start during the DONE cycle is ignored
    exp_err = 0;
    start_run(4);
    run_until(t0 + 41);
    start = 1'b1;
    step();
    check("start_in_done_busy", 32'(busy), 32'(0));
    check("start_in_done_enable", 32'(agu_enable), 32'(0));
    run_until(t0 + 46);
    check("start_in_done_rise_pending", 32'(exp_rise_q.size()), 32'(0));

    // rst during DRAIN
    step();
    force_l = 1'b1;
    start_run(4);
    run_until(t0 + 17);
    force_l = 1'b0;
    run_until(t0 + 18);
    check("drain_before_rst_busy", 32'(busy), 32'(1));
    check("drain_before_rst_err", 32'(err), 32'(1));
    rst = 1'b1;
    wb_sched.delete();
    step();
    check_reset_values("rst_in_drain");
    rst = 1'b0;
    exp_rise_q.delete();
    exp_done_q.delete();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
